ym_slot_sequencer: RTL and testbench
====================================

Name: ym_slot_sequencer

Overview:
- Parametrised slot sequencer and algorithm-routing decoder for the FM operator pipeline.
- Generalises the fixed 6-channel x 4-operator slot FSM to any channel count and group size.
- Adds registered decode outputs, external frame resync, freeze/single-step, a frame counter and a programmable timer-tick slot.
- Sits between the register file (supplies `connect`) and the operator and accumulator pipelines.

Parameters:
- NUM_CH, 6, channels per frame; must be a multiple of CH_PER_GRP.
- CH_PER_GRP, 3, channels per bank (low counter modulus), 1..4.
- NUM_OP, 4, operator groups per frame; fixed at 4 for algorithm decode.
- FRAME_CNT_W, 8, width of the free-running frame counter.
- TICK_SLOT, 2, slot index on which `timer_tick` fires.

Ports:
- MCLK  in  1  master clock.
- reset  in  1  asynchronous, active-high; clears all state.
- c1  in  1  phase-1 enable; next state is latched on an MCLK edge with c1=1.
- c2  in  1  phase-2 enable; latched state is committed on an MCLK edge with c2=1.
- sync  in  1  synchronous frame restart; sampled on c1.
- freeze  in  1  holds the slot position; sampled on c1.
- step  in  1  advances one slot while frozen; sampled on c1.
- connect  in  3  algorithm number 0..7.
- slot  out  $clog2(NUM_CH*NUM_OP)  current slot index S.
- ch_idx  out  $clog2(NUM_CH)  channel of the current slot.
- grp_idx  out  2  operator group g = S / NUM_CH.
- bank_idx  out  $clog2(CH_PER_GRP)  low counter value.
- frame_start  out  1  high while S==0.
- frame_end  out  1  high while S==NUM_CH*NUM_OP-1.
- timer_tick  out  1  one-MCLK pulse on entry to TICK_SLOT.
- fb_sel  out  1  feedback select.
- alg_op2, alg_cur1, alg_cur2, alg_op1_0, alg_out  out  1 each  registered routing controls.
- frame_cnt  out  FRAME_CNT_W  completed-frame count.

Behaviour:
- Reset (async): S=0; latch=0; frame_cnt=0; fb_sel=1; timer_tick=0; all alg_* outputs=0.
- Reset mid-frame: release restarts at S=0 with no tick and no frame_cnt increment.
- Counter structure: low counter L runs 0..CH_PER_GRP-1; high counter H runs 0..NUM_CH*NUM_OP/CH_PER_GRP-1.
  - S = H*CH_PER_GRP + L.
  - H increments when L wraps.
  - H wraps to 0 after its last value.
- Two-phase update: on a c1 edge the latch takes the next S; on a c2 edge S takes the latch.
  - Outputs derived from S change on the MCLK edge after c2.
  - Between phases, S is stable.
- Next-S priority, evaluated at c1:
  1. sync=1 gives 0.
  2. freeze=1 and step=0 gives S.
  3. Otherwise (S+1) mod (NUM_CH*NUM_OP).
- sync while frozen still forces 0.
- step without freeze is ignored and behaves as a normal advance.
- frame_cnt increments (wrapping) on commit of a wrap from the last slot to 0.
  - A sync-forced 0 does not increment it.
  - A frozen hold at the last slot increments nothing.
- Derived fields:
  - ch_idx = S mod NUM_CH.
  - grp_idx = S / NUM_CH.
  - bank_idx = L.
- timer_tick: rising-edge detect of (S==TICK_SLOT), registered on c1.
  - High for exactly one MCLK cycle per entry.
  - No re-fire while frozen on TICK_SLOT.
- fb_sel: the inverse of a one-slot-delayed (g==2) flag, shifted on c1/c2.
  - Low during the slot after each group-2 slot, high otherwise.
- Algorithm decode (A = connect), evaluated from the committed S and registered on c2 together with S:
  - alg_op2 = (g0 & A∈{0,1,2}) | (g2 & A==3)
  - alg_cur1 = (g1 & A∈{0,3,4,5,6}) | (g2 & A∈{0,1,3,4})
  - alg_cur2 = g2 & A==2
  - alg_op1_0 = (g0 & A∈{1,5}) | (g2 & A∈{2,5}) | g3
  - alg_out = g0 | (g1 & A==7) | (g2 & A∈{5,6,7}) | (g3 & A∈{4..7})
- A change of `connect` takes effect on the next c2 commit; there is no retro-effect on the current slot.
- Elaboration checks:
  - NUM_CH mod CH_PER_GRP != 0 is a fatal elaboration error.
  - NUM_OP != 4 is a fatal elaboration error.

Test Plan:
- Defaults, c1/c2 alternating, 60 slots -> S sequence 0..23,0..23,0..11; frame_cnt=2 after the second wrap; frame_start high at S=0 only; timer_tick pulses exactly at S=2 entries (3 pulses).
- NUM_CH=9, CH_PER_GRP=3 -> S wraps at 35; ch_idx at S=20 is 2; grp_idx at S=20 is 2; bank_idx at S=20 is 2.
- freeze=1 at S=5 for 10 slots, with step pulsed twice -> S stays 5, then 6, then 7; frame_cnt unchanged; no extra timer_tick.
- sync at S=17 -> next commit S=0; frame_cnt unchanged; resumes at 1.
- connect=7, sweep S -> alg_out=1 in all 24 slots; alg_op2=0 and alg_cur1=0 everywhere. connect=2 -> alg_cur2=1 only at S=12..17.
- reset asserted asynchronously at S=13 between c1 and c2 -> immediate S=0, fb_sel=1, alg_*=0; on release counting resumes from 0 with no tick.

Source files
------------

// File: rtl/ym_slot_sequencer.sv
// Slot sequencer and algorithm-routing decoder for the FM operator pipeline.
// A two-phase (c1 latch / c2 commit) slot counter walks NUM_CH*NUM_OP slots.
// Per-slot channel, group, bank, timing strobes and algorithm routing controls
// are derived from it, all registered.
module ym_slot_sequencer #(
    parameter int NUM_CH      = 6,
    parameter int CH_PER_GRP  = 3,
    parameter int NUM_OP      = 4,
    parameter int FRAME_CNT_W = 8,
    parameter int TICK_SLOT   = 2,
    localparam int NUM_SLOTS  = NUM_CH * NUM_OP,
    localparam int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW         = (CH_PER_GRP > 1) ? $clog2(CH_PER_GRP) : 1
) (
    input  logic                   MCLK,
    input  logic                   reset,
    input  logic                   c1,
    input  logic                   c2,
    input  logic                   sync,
    input  logic                   freeze,
    input  logic                   step,
    input  logic [2:0]             connect,
    output logic [SW-1:0]          slot,
    output logic [CW-1:0]          ch_idx,
    output logic [1:0]             grp_idx,
    output logic [LW-1:0]          bank_idx,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   timer_tick,
    output logic                   fb_sel,
    output logic                   alg_op2,
    output logic                   alg_cur1,
    output logic                   alg_cur2,
    output logic                   alg_op1_0,
    output logic                   alg_out,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int NUM_H = NUM_SLOTS / CH_PER_GRP;
    localparam int HW    = (NUM_H > 1) ? $clog2(NUM_H) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(NUM_SLOTS - 1);
    localparam logic [SW-1:0] S_TICK = SW'(TICK_SLOT);
    localparam logic [HW-1:0] H_LAST = HW'(NUM_H - 1);
    localparam logic [LW-1:0] L_LAST = LW'(CH_PER_GRP - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);

    if (NUM_CH % CH_PER_GRP != 0) begin : g_bad_ch
        $fatal(1, "ym_slot_sequencer: NUM_CH must be a multiple of CH_PER_GRP");
    end
    if (NUM_OP != 4) begin : g_bad_op
        $fatal(1, "ym_slot_sequencer: NUM_OP must be 4");
    end
    if (CH_PER_GRP < 1 || CH_PER_GRP > 4) begin : g_bad_grp
        $fatal(1, "ym_slot_sequencer: CH_PER_GRP must be 1..4");
    end

    // Slot position kept in every derived form so no divider/multiplier is needed.
    typedef struct packed {
        logic [SW-1:0] s;    // slot index S
        logic [HW-1:0] h;    // high counter H
        logic [LW-1:0] l;    // low counter L (bank)
        logic [CW-1:0] ch;   // S mod NUM_CH
        logic [1:0]    g;    // S / NUM_CH
    } pos_t;

    typedef struct packed {
        logic op2;
        logic cur1;
        logic cur2;
        logic op1_0;
        logic out;
    } alg_t;

    pos_t cur_pos;
    pos_t lat_pos;
    logic lat_wrap;     // latched next position is a frame wrap
    logic g2_lat;       // group-2 flag of the slot sampled at c1
    logic tick_seen;    // S was TICK_SLOT at the previous c1
    alg_t alg_q;

    // One-slot advance of every counter form; the frame wraps when L and H both wrap.
    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n = p;
        if (p.l == L_LAST) begin
            n.l = '0;
            n.h = (p.h == H_LAST) ? '0 : p.h + 1'b1;
        end else begin
            n.l = p.l + 1'b1;
        end
        if (p.l == L_LAST && p.h == H_LAST) begin
            n.s  = '0;
            n.ch = '0;
            n.g  = '0;
        end else begin
            n.s = p.s + 1'b1;
            if (p.ch == C_LAST) begin
                n.ch = '0;
                n.g  = p.g + 1'b1;
            end else begin
                n.ch = p.ch + 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic is_last(input pos_t p);
        return (p.l == L_LAST) && (p.h == H_LAST);
    endfunction

    // Algorithm routing for operator group g under algorithm a.
    function automatic alg_t decode(input logic [1:0] g, input logic [2:0] a);
        alg_t r;
        logic g0, g1, g2, g3;
        g0 = (g == 2'd0);
        g1 = (g == 2'd1);
        g2 = (g == 2'd2);
        g3 = (g == 2'd3);
        r.op2   = (g0 && a <= 3'd2) || (g2 && a == 3'd3);
        r.cur1  = (g1 && (a == 3'd0 || (a >= 3'd3 && a <= 3'd6))) ||
                  (g2 && (a == 3'd0 || a == 3'd1 || a == 3'd3 || a == 3'd4));
        r.cur2  = g2 && a == 3'd2;
        r.op1_0 = (g0 && (a == 3'd1 || a == 3'd5)) ||
                  (g2 && (a == 3'd2 || a == 3'd5)) || g3;
        r.out   = g0 || (g1 && a == 3'd7) || (g2 && a >= 3'd5) || (g3 && a >= 3'd4);
        return r;
    endfunction

    // Two-phase sequencing: c1 latches next position and strobes, c2 commits them.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            cur_pos    <= '0;
            lat_pos    <= '0;
            lat_wrap   <= 1'b0;
            g2_lat     <= 1'b0;
            tick_seen  <= 1'b0;
            timer_tick <= 1'b0;
            fb_sel     <= 1'b1;
            alg_q      <= '0;
            frame_cnt  <= '0;
        end else begin
            timer_tick <= 1'b0;
            // NOTE: the c2 commit is written before the c1 latch so that, if both
            // phases ever coincide, the later non-blocking write of lat_wrap from
            // c1 wins while c2 still commits the previously latched values.
            if (c2) begin
                cur_pos  <= lat_pos;
                alg_q    <= decode(lat_pos.g, connect);
                fb_sel   <= ~g2_lat;
                lat_wrap <= 1'b0;
                if (lat_wrap) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (c1) begin
                tick_seen  <= (cur_pos.s == S_TICK);
                timer_tick <= (cur_pos.s == S_TICK) && !tick_seen;
                g2_lat     <= (cur_pos.g == 2'd2);
                if (sync) begin
                    lat_pos  <= '0;
                    lat_wrap <= 1'b0;
                end else if (freeze && !step) begin
                    lat_pos  <= cur_pos;
                    lat_wrap <= 1'b0;
                end else begin
                    lat_pos  <= advance(cur_pos);
                    lat_wrap <= is_last(cur_pos);
                end
            end
        end
    end

    assign slot        = cur_pos.s;
    assign ch_idx      = cur_pos.ch;
    assign grp_idx     = cur_pos.g;
    assign bank_idx    = cur_pos.l;
    assign frame_start = (cur_pos.s == '0);
    assign frame_end   = (cur_pos.s == S_LAST);
    assign alg_op2     = alg_q.op2;
    assign alg_cur1    = alg_q.cur1;
    assign alg_cur2    = alg_q.cur2;
    assign alg_op1_0   = alg_q.op1_0;
    assign alg_out     = alg_q.out;

endmodule

// File: tb/tb_ym_slot_sequencer.sv
// Self-checking bench for ym_slot_sequencer: a 6-channel and a 9-channel
// instance share stimulus and are compared against a slot-level reference model.
module tb_ym_slot_sequencer;

    localparam int TICK = 2;

    logic       MCLK = 1'b0;
    logic       reset, c1, c2, sync, freeze, step;
    logic [2:0] connect;

    logic [4:0] slot6;  logic [2:0] ch6;  logic [1:0] grp6;  logic [1:0] bank6;
    logic fs6, fe6, tick6, fb6, op2_6, cur1_6, cur2_6, op10_6, out6;
    logic [7:0] fc6;
    logic [5:0] slot9;  logic [3:0] ch9;  logic [1:0] grp9;  logic [1:0] bank9;
    logic fs9, fe9, tick9, fb9, op2_9, cur1_9, cur2_9, op10_9, out9;
    logic [7:0] fc9;

    ym_slot_sequencer dut6 (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .sync(sync), .freeze(freeze),
        .step(step), .connect(connect), .slot(slot6), .ch_idx(ch6), .grp_idx(grp6),
        .bank_idx(bank6), .frame_start(fs6), .frame_end(fe6), .timer_tick(tick6),
        .fb_sel(fb6), .alg_op2(op2_6), .alg_cur1(cur1_6), .alg_cur2(cur2_6),
        .alg_op1_0(op10_6), .alg_out(out6), .frame_cnt(fc6)
    );

    ym_slot_sequencer #(.NUM_CH(9), .CH_PER_GRP(3)) dut9 (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .sync(sync), .freeze(freeze),
        .step(step), .connect(connect), .slot(slot9), .ch_idx(ch9), .grp_idx(grp9),
        .bank_idx(bank9), .frame_start(fs9), .frame_end(fe9), .timer_tick(tick9),
        .fb_sel(fb9), .alg_op2(op2_9), .alg_cur1(cur1_9), .alg_cur2(cur2_9),
        .alg_op1_0(op10_9), .alg_out(out9), .frame_cnt(fc9)
    );

    always #5 MCLK = ~MCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    // Reference model, one entry per instance (0: 6 channels, 1: 9 channels).
    int   nch [2] = '{6, 9};
    int   nsl [2] = '{24, 36};
    int   m_s [2];
    int   m_next [2];
    int   m_frame [2];
    bit   m_wrap [2];
    bit   m_entered [2];
    bit   m_fb [2];
    logic [4:0] m_alg [2];

    // Routing truth table: bit A of each mask is the control for algorithm A in group g.
    logic [7:0] op2_m  [4] = '{8'h07, 8'h00, 8'h08, 8'h00};
    logic [7:0] cur1_m [4] = '{8'h00, 8'h79, 8'h1B, 8'h00};
    logic [7:0] cur2_m [4] = '{8'h00, 8'h00, 8'h04, 8'h00};
    logic [7:0] op10_m [4] = '{8'h00, 8'h22, 8'h24, 8'hFF};
    logic [7:0] out_m  [4] = '{8'hFF, 8'h80, 8'hE0, 8'hF0};

    function automatic logic [4:0] alg_ref(input int g, input logic [2:0] a);
        logic [7:0] m0, m1, m2, m3, m4;
        m0 = op2_m[g];  m1 = cur1_m[g];  m2 = cur2_m[g];
        m3 = op10_m[g]; m4 = out_m[g];
        return {m0[a], m1[a], m2[a], m3[a], m4[a]};
    endfunction

    // op1_0 for group 0 is A in {1,5}; patch table entry 0 (declared above in group order).
    initial begin
        op10_m[0] = 8'h22;
        op10_m[1] = 8'h00;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s[k] = 0; m_frame[k] = 0; m_entered[k] = 1'b0;
            m_fb[k] = 1'b1; m_alg[k] = '0; m_wrap[k] = 1'b0;
        end
    endtask

    task automatic check_dut(input int k, input logic [63:0] s, input logic [63:0] ch,
                             input logic [63:0] g, input logic [63:0] b, input logic fs,
                             input logic fe, input logic tk, input logic fb,
                             input logic [4:0] alg, input logic [63:0] fc);
        string p;
        p = (k == 0) ? "d6" : "d9";
        check({p, "_slot"}, s, m_s[k]);
        check({p, "_ch_idx"}, ch, m_s[k] % nch[k]);
        check({p, "_grp_idx"}, g, m_s[k] / nch[k]);
        check({p, "_bank_idx"}, b, m_s[k] % 3);
        check({p, "_frame_start"}, fs, m_s[k] == 0);
        check({p, "_frame_end"}, fe, m_s[k] == nsl[k] - 1);
        check({p, "_tick_idle"}, tk, 1'b0);
        check({p, "_fb_sel"}, fb, m_fb[k]);
        check({p, "_alg"}, alg, m_alg[k]);
        check({p, "_frame_cnt"}, fc, m_frame[k]);
    endtask

    task automatic check_all();
        check_dut(0, slot6, ch6, grp6, bank6, fs6, fe6, tick6, fb6,
                  {op2_6, cur1_6, cur2_6, op10_6, out6}, fc6);
        check_dut(1, slot9, ch9, grp9, bank9, fs9, fe9, tick9, fb9,
                  {op2_9, cur1_9, cur2_9, op10_9, out9}, fc9);
    endtask

    // One slot: c1 phase (inputs sampled) then c2 phase (commit), model stepped alongside.
    task automatic do_slot(input bit s_sync, input bit s_freeze, input bit s_step,
                           input logic [2:0] a);
        bit texp [2];
        @(negedge MCLK);
        sync = s_sync; freeze = s_freeze; step = s_step; connect = a;
        c1 = 1'b1; c2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (s_sync) begin
                m_next[k] = 0; m_wrap[k] = 1'b0;
            end else if (s_freeze && !s_step) begin
                m_next[k] = m_s[k]; m_wrap[k] = 1'b0;
            end else begin
                m_next[k] = (m_s[k] + 1) % nsl[k];
                m_wrap[k] = (m_s[k] == nsl[k] - 1);
            end
            texp[k] = m_entered[k];
            m_entered[k] = 1'b0;
        end
        @(posedge MCLK); #1;
        check("d6_timer_tick", tick6, texp[0]);
        check("d9_timer_tick", tick9, texp[1]);
        if (tick6) tick_cnt++;
        @(negedge MCLK);
        c1 = 1'b0; c2 = 1'b1; sync = 1'b0; freeze = 1'b0; step = 1'b0;
        @(posedge MCLK); #1;
        for (int k = 0; k < 2; k++) begin
            m_fb[k] = !((m_s[k] / nch[k]) == 2);
            m_entered[k] = (m_next[k] == TICK) && (m_s[k] != TICK);
            m_s[k] = m_next[k];
            if (m_wrap[k]) m_frame[k] = (m_frame[k] + 1) % 256;
            m_alg[k] = alg_ref(m_s[k] / nch[k], a);
        end
        check_all();
        if (m_s[1] == 20) begin
            check("d9_ch_at_20", ch9, 2);
            check("d9_grp_at_20", grp9, 2);
            check("d9_bank_at_20", bank9, 2);
        end
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 60 && m_s[0] != target; i++) begin
            do_slot(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
        end
        check("reach_slot", slot6, target);
    endtask

    initial begin
        int f0, tc;
        reset = 1'b1; c1 = 1'b0; c2 = 1'b0; sync = 1'b0; freeze = 1'b0; step = 1'b0;
        connect = 3'd0;
        model_reset();
        repeat (3) @(negedge MCLK);
        check_all();
        reset = 1'b0;
        @(posedge MCLK); #1;
        check_all();

        // Free-running frames with random algorithms.
        tick_cnt = 0;
        for (int i = 0; i < 60; i++) do_slot(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
        check("ticks_in_60", tick_cnt, 3);
        check("d6_frames_60", fc6, 2);
        check("d9_frames_60", fc9, 1);
        check("d6_slot_60", slot6, 12);

        // A connect change with no commit leaves the routing untouched.
        @(negedge MCLK); c1 = 1'b0; c2 = 1'b0; connect = ~connect;
        @(posedge MCLK); #1;
        check("no_retro_alg", {op2_6, cur1_6, cur2_6, op10_6, out6}, m_alg[0]);

        // Algorithm sweeps.
        for (int i = 0; i < 24; i++) begin
            do_slot(1'b0, 1'b0, 1'b0, 3'd7);
            check("alg7_out", out6, 1'b1);
            check("alg7_op2", op2_6, 1'b0);
            check("alg7_cur1", cur1_6, 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            do_slot(1'b0, 1'b0, 1'b0, 3'd2);
            check("alg2_cur2", cur2_6, (m_s[0] >= 12) && (m_s[0] <= 17));
        end

        // Freeze at S=5 with two single steps.
        advance_to(5);
        f0 = m_frame[0]; tc = tick_cnt;
        for (int i = 0; i < 10; i++) begin
            do_slot(1'b0, 1'b1, (i == 3) || (i == 7), 3'($urandom_range(0, 7)));
        end
        check("freeze_slot", slot6, 7);
        check("freeze_frames", fc6, f0);
        check("freeze_ticks", tick_cnt, tc);

        // Freeze on the tick slot: one tick for the entry, none while held.
        advance_to(TICK);
        tc = tick_cnt;
        for (int i = 0; i < 4; i++) do_slot(1'b0, 1'b1, 1'b0, 3'd0);
        check("freeze_tick_once", tick_cnt, tc + 1);

        // Step without freeze is a plain advance.
        for (int i = 0; i < 3; i++) do_slot(1'b0, 1'b0, 1'b1, 3'd1);

        // Sync at S=17, then resume; sync while frozen; sync on the last slot.
        advance_to(17);
        f0 = m_frame[0];
        do_slot(1'b1, 1'b0, 1'b0, 3'd3);
        check("sync_slot", slot6, 0);
        check("sync_frames", fc6, f0);
        do_slot(1'b0, 1'b0, 1'b0, 3'd3);
        check("sync_resume", slot6, 1);
        do_slot(1'b1, 1'b1, 1'b0, 3'd4);
        check("sync_frozen", slot6, 0);
        advance_to(23);
        f0 = m_frame[0];
        do_slot(1'b1, 1'b0, 1'b0, 3'd5);
        check("sync_last_frames", fc6, f0);

        // Random control mix.
        for (int i = 0; i < 80; i++) begin
            do_slot($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset between c1 and c2 at S=13.
        advance_to(13);
        @(negedge MCLK); c1 = 1'b1; c2 = 1'b0;
        @(posedge MCLK); #3;
        reset = 1'b1;
        #1;
        check("rst_slot", slot6, 0);
        check("rst_fb_sel", fb6, 1'b1);
        check("rst_alg", {op2_6, cur1_6, cur2_6, op10_6, out6}, 5'b0);
        check("rst_frames", fc6, 0);
        check("rst_slot9", slot9, 0);
        model_reset();
        @(negedge MCLK); c1 = 1'b0; c2 = 1'b0;
        repeat (2) @(negedge MCLK);
        reset = 1'b0;
        @(posedge MCLK); #1;
        check_all();
        for (int i = 0; i < 30; i++) do_slot(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));

        @(negedge MCLK); c1 = 1'b0; c2 = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
